// File: rtl/decode_issue.sv
// Decode/issue front end: classifies register usage, tracks in-flight writes with
// per-register counters and issues into a registered valid/ready output slot.
module decode_issue #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned CNT_WIDTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] next_pc_in,
   input  logic [31:0]     instr_in,
   input  logic            valid_in,
   output logic            ready_in,
   input  logic            invalidate,
   input  logic            retire_valid,
   input  logic [4:0]      retire_rd,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] next_pc_out,
   output logic [31:0]     instr_out,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   output logic [4:0]      rd_addr,
   output logic            uses_rs1,
   output logic            uses_rs2,
   output logic            exception,
   output logic [3:0]      ecause,
   output logic            valid_out,
   input  logic            ready_out,
   output logic            sb_error
);

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpOpImm  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpOp     = 7'b0110011;
   localparam logic [6:0] OpFence  = 7'b0001111;
   localparam logic [6:0] OpSystem = 7'b1110011;

   localparam logic [5:0]           RegLimit = 6'(REG_COUNT);
   localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

   // Instruction fields
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rs1_f;
   logic [4:0] rs2_f;
   logic [4:0] rd_f;

   assign opcode = instr_in[6:0];
   assign rd_f   = instr_in[11:7];
   assign funct3 = instr_in[14:12];
   assign rs1_f  = instr_in[19:15];
   assign rs2_f  = instr_in[24:20];

   // Classification
   logic has_rs1;
   logic has_rs2;
   logic has_rd;
   logic known_op;
   logic idx_bad;
   logic illegal;
   logic src_rs1;
   logic src_rs2;
   logic writes_rd;
   logic [4:0] rd_dec;

   always_comb begin
      has_rs1  = 1'b0;
      has_rs2  = 1'b0;
      has_rd   = 1'b0;
      known_op = 1'b1;
      case (opcode)
         OpLui, OpAuipc, OpJal: begin
            has_rd = 1'b1;
         end
         OpJalr, OpLoad, OpOpImm: begin
            has_rs1 = 1'b1;
            has_rd  = 1'b1;
         end
         OpBranch, OpStore: begin
            has_rs1 = 1'b1;
            has_rs2 = 1'b1;
         end
         OpOp: begin
            has_rs1 = 1'b1;
            has_rs2 = 1'b1;
            has_rd  = 1'b1;
         end
         OpFence: begin
            known_op = 1'b1;
         end
         OpSystem: begin
            case (funct3)
               3'b001, 3'b010, 3'b011: begin
                  has_rs1 = 1'b1;
                  has_rd  = 1'b1;
               end
               3'b101, 3'b110, 3'b111: begin
                  has_rd = 1'b1;
               end
               3'b000: begin
                  known_op = 1'b1;
               end
               default: begin
                  known_op = 1'b0;
               end
            endcase
         end
         default: begin
            known_op = 1'b0;
         end
      endcase
   end

   assign idx_bad = (has_rs1 && ({1'b0, rs1_f} >= RegLimit)) ||
                    (has_rs2 && ({1'b0, rs2_f} >= RegLimit)) ||
                    (has_rd  && ({1'b0, rd_f}  >= RegLimit));
   assign illegal   = !known_op || idx_bad;
   assign src_rs1   = has_rs1 && !illegal;
   assign src_rs2   = has_rs2 && !illegal;
   assign writes_rd = has_rd && !illegal && (rd_f != 5'd0);
   assign rd_dec    = writes_rd ? rd_f : 5'd0;

   // Scoreboard
   logic [CNT_WIDTH-1:0] cnt_q [REG_COUNT];
   logic [CNT_WIDTH-1:0] cnt_d [REG_COUNT];
   logic [CNT_WIDTH-1:0] rs1_cnt;
   logic [CNT_WIDTH-1:0] rs2_cnt;
   logic [CNT_WIDTH-1:0] rd_cnt;
   logic [REG_COUNT-1:0] inc_vec;
   logic [REG_COUNT-1:0] dec_vec;
   logic                 sb_error_q;
   logic                 sb_error_d;
   logic                 hazard;
   logic                 issue;
   logic                 valid_q;

   // Indices outside REG_COUNT read as zero; they are only reachable on illegal encodings.
   always_comb begin
      rs1_cnt = '0;
      rs2_cnt = '0;
      rd_cnt  = '0;
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
         if (rs1_f == 5'(i)) rs1_cnt = cnt_q[i];
         if (rs2_f == 5'(i)) rs2_cnt = cnt_q[i];
         if (rd_f  == 5'(i)) rd_cnt  = cnt_q[i];
      end
   end

   assign hazard = (src_rs1 && (rs1_f != 5'd0) && (rs1_cnt != '0)) ||
                   (src_rs2 && (rs2_f != 5'd0) && (rs2_cnt != '0)) ||
                   (writes_rd && (rd_cnt == CntMax));

   assign ready_in = !invalidate && !hazard && (!valid_q || ready_out);
   assign issue    = valid_in && ready_in;

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int unsigned i = 1; i < REG_COUNT; i++) begin
         inc_vec[i] = issue && writes_rd && (rd_f == 5'(i));
         dec_vec[i] = retire_valid && (retire_rd == 5'(i));
      end
   end

   // Simultaneous issue and retire on one register cancel out.
   always_comb begin
      sb_error_d = sb_error_q;
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (invalidate) begin
            cnt_d[i] = '0;
         end else if (inc_vec[i] && !dec_vec[i]) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end else if (dec_vec[i] && !inc_vec[i]) begin
            if (cnt_q[i] == '0) begin
               sb_error_d = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            cnt_q[i] <= '0;
         end
         sb_error_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         sb_error_q <= sb_error_d;
      end
   end

   // Output slot
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] next_pc_q;
   logic [31:0]     instr_q;
   logic [4:0]      rs1_q;
   logic [4:0]      rs2_q;
   logic [4:0]      rd_q;
   logic            uses_rs1_q;
   logic            uses_rs2_q;
   logic            exception_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         next_pc_q   <= '0;
         instr_q     <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         uses_rs1_q  <= 1'b0;
         uses_rs2_q  <= 1'b0;
         exception_q <= 1'b0;
      end else if (invalidate) begin
         valid_q <= 1'b0;
      end else if (issue) begin
         valid_q     <= 1'b1;
         pc_q        <= pc_in;
         next_pc_q   <= next_pc_in;
         instr_q     <= instr_in;
         rs1_q       <= rs1_f;
         rs2_q       <= rs2_f;
         rd_q        <= rd_dec;
         uses_rs1_q  <= src_rs1;
         uses_rs2_q  <= src_rs2;
         exception_q <= illegal;
      end else if (ready_out) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_out   = valid_q;
   assign pc_out      = pc_q;
   assign next_pc_out = next_pc_q;
   assign instr_out   = instr_q;
   assign rs1_addr    = rs1_q;
   assign rs2_addr    = rs2_q;
   assign rd_addr     = rd_q;
   assign uses_rs1    = uses_rs1_q;
   assign uses_rs2    = uses_rs2_q;
   assign exception   = exception_q;
   assign ecause      = exception_q ? 4'd2 : 4'd0;
   assign sb_error    = sb_error_q;

endmodule
